// File: rtl/reg_file_mp.sv
// -----------------------------------------------------------------------------
// reg_file_mp
//
// Multi-read-port integer register file for the decode stage. Every register
// carries a pending-write (busy) bit, so issue logic can detect operands that
// still wait for writeback. After reset, a clear sequencer writes zero into
// every register, one register per cycle. The file reports init_done once that
// sequence has finished. While the clear runs, writes and issues are ignored,
// and all read ports return 0 / not-busy.
//
// Parameters
//   XLEN   data width in bits
//   NREGS  number of architectural registers (power of two, >= 4)
//   NRD    number of read ports (1..4)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset, forces the clear sequence
//   ra         read addresses, port i at [i*AW +: AW]
//   rdata      read data, port i at [i*XLEN +: XLEN]
//   rbusy      per-port flag: addressed register has an outstanding write
//   we/wa/wd   writeback enable / address / data
//   iss_valid  an instruction was issued that will write iss_rd
//   iss_rd     destination register of the issued instruction
//   init_done  clear sequence finished, file usable
//   a0         contents of register 10 (0 if NREGS <= 10 or not initialised)
//
// Build option
//   REGFILE_BYPASS_EN  when defined, a same-cycle writeback is forwarded
//                      combinationally to every read port that addresses it,
//                      and that port's rbusy is masked. When undefined, reads
//                      return the pre-edge contents.
// -----------------------------------------------------------------------------
module reg_file_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic                init_done,
  output logic [XLEN-1:0]     a0
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [NREGS-1:0] busy_q, busy_d;

  // Register array holds data only; it is cleared by the sequencer rather than
  // by the reset network.
  logic [XLEN-1:0]  regs_q [NREGS];

  logic             run;
  logic             clr_en;
  logic             wb_hit;
  logic             iss_hit;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [XLEN-1:0]  wr_data;

  // ---------------------------------------------------------------------------
  // FSM: state register (with clear counter and scoreboard)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + AW'(1);
        // The edge that clears the last register also enters RUN.
        if (cnt_q == LAST_IDX) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    run       = 1'b0;
    clr_en    = 1'b0;
    init_done = 1'b0;
    unique case (state_q)
      S_INIT: begin
        clr_en = 1'b1;
      end
      S_RUN: begin
        run       = 1'b1;
        init_done = 1'b1;
      end
      default: begin
        clr_en = 1'b0;
      end
    endcase
  end

  // Register 0 is hard-wired, so neither writebacks nor issues aimed at it have
  // any effect on data or scoreboard.
  assign wb_hit  = run && we && (wa != '0);
  assign iss_hit = run && iss_valid && (iss_rd != '0);

  // ---------------------------------------------------------------------------
  // Scoreboard next state. The set is applied after the clear, so that when a
  // writeback and a new issue hit the same register, the newer instruction
  // keeps ownership of it.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_d = busy_q;
    if (wb_hit) begin
      busy_d[wa] = 1'b0;
    end
    if (iss_hit) begin
      busy_d[iss_rd] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Single write port, shared by the clear sequencer and writeback
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_en   = clr_en | wb_hit;
    wr_addr = wa;
    wr_data = wd;
    if (clr_en) begin
      wr_addr = cnt_q;
      wr_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] addr;
    logic          byp;

    assign addr = ra[p*AW +: AW];

`ifdef REGFILE_BYPASS_EN
    // wb_hit already excludes register 0 and the INIT state.
    assign byp = wb_hit && (wa == addr);
`else
    assign byp = 1'b0;
`endif

    assign rdata[p*XLEN +: XLEN] = (!run || (addr == '0)) ? '0 :
                                   byp                    ? wd :
                                                            regs_q[addr];

    assign rbusy[p] = run && busy_q[addr] && !byp;
  end

  // ---------------------------------------------------------------------------
  // Debug view of register 10. Gated to 0 until the clear has reached it.
  // ---------------------------------------------------------------------------
  if (NREGS > 10) begin : g_a0
    localparam logic [AW-1:0] A0_IDX = AW'(10);
    assign a0 = run ? regs_q[A0_IDX] : '0;
  end else begin : g_no_a0
    assign a0 = '0;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 4;
  localparam int AW    = 5;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk;
  logic                rst_n;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                we;
  logic [AW-1:0]       wa;
  logic [XLEN-1:0]     wd;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                init_done;
  logic [XLEN-1:0]     a0;

  int errors = 0;
  int checks = 0;

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ra        (ra),
    .rdata     (rdata),
    .rbusy     (rbusy),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .init_done (init_done),
    .a0        (a0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%h expected=%h", nm, $time, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: the file becomes usable after NREGS edges with rst_n
  // high, holding all zeros; afterwards it is an array plus a set of pending
  // destinations.
  // ---------------------------------------------------------------------------
  logic [31:0] m_regs [NREGS];
  logic [NREGS-1:0] m_busy;
  int m_edges;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edges <= 0;
      m_busy  <= '0;
      for (int i = 0; i < NREGS; i++) m_regs[i] <= '0;
    end else if (m_edges < NREGS) begin
      m_edges <= m_edges + 1;
    end else begin
      if (we && wa != 0) begin
        m_regs[wa] <= wd;
        m_busy[wa] <= 1'b0;
      end
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] <= 1'b1;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    logic        c_run;
    logic [4:0]  c_a;
    logic        c_fwd;
    logic [31:0] c_d;
    logic        c_b;
    c_run = rst_n && (m_edges >= NREGS);
    chk("cyc_init_done", 32'(init_done), 32'(c_run));
    chk("cyc_a0", a0, c_run ? m_regs[10] : 32'h0);
    for (int p = 0; p < NRD; p++) begin
      c_a   = ra[p*AW +: AW];
      c_fwd = BYP && c_run && we && (wa == c_a) && (c_a != 0);
      if (!c_run || c_a == 0) c_d = 32'h0;
      else if (c_fwd)         c_d = wd;
      else                    c_d = m_regs[c_a];
      c_b = c_run && m_busy[c_a] && !c_fwd;
      chk("cyc_rdata", rdata[p*XLEN +: XLEN], c_d);
      chk("cyc_rbusy", 32'(rbusy[p]), 32'(c_b));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] c, input logic [4:0] d);
    ra = {d, c, b, a};
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    we = 1'b1; wa = addr; wd = data;
    tick();
    we = 1'b0;
  endtask

  task automatic run_clear();
    rst_n = 1'b1;
    repeat (31) tick();
    chk("init_done_edge31", 32'(init_done), 32'h0);
    tick();
    chk("init_done_edge32", 32'(init_done), 32'h1);
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0;
    iss_valid = 1'b0; iss_rd = '0; ra = '0;
    repeat (2) tick();
    set_ra(5'd3, 5'd10, 5'd31, 5'd1);
    #2;
    chk("reset_init_done", 32'(init_done), 32'h0);
    chk("reset_a0", a0, 32'h0);
    chk("reset_rdata0", rdata[31:0], 32'h0);
    chk("reset_rbusy", 32'(rbusy), 32'h0);

    // Clear sequence and all-zero contents.
    run_clear();
    for (int r = 0; r < NREGS; r++) begin
      set_ra(5'(r), 5'(r), 5'(r), 5'(r));
      #2;
      chk("cleared_reg", rdata[31:0], 32'h0);
      tick();
    end

    // Zero is written like any other value; register 0 stays 0.
    wr(5'd5, 32'hDEAD_BEEF);
    set_ra(5'd5, 5'd0, 5'd0, 5'd0);
    #2;
    chk("reg5_deadbeef", rdata[31:0], 32'hDEAD_BEEF);
    wr(5'd5, 32'h0000_0000);
    #2;
    chk("reg5_zero_write", rdata[31:0], 32'h0);
    wr(5'd0, 32'h0000_1234);
    set_ra(5'd0, 5'd5, 5'd0, 5'd0);
    #2;
    chk("reg0_reads_zero", rdata[31:0], 32'h0);

    // Same-cycle write and read of register 7.
    wr(5'd7, 32'h1111_1111);
    set_ra(5'd7, 5'd0, 5'd0, 5'd0);
    we = 1'b1; wa = 5'd7; wd = 32'hCAFE_F00D;
    #2;
    chk("reg7_pre_edge", rdata[31:0], BYP ? 32'hCAFE_F00D : 32'h1111_1111);
    tick();
    we = 1'b0;
    #2;
    chk("reg7_post_edge", rdata[31:0], 32'hCAFE_F00D);

    // Scoreboard.
    iss_valid = 1'b1; iss_rd = 5'd3;
    set_ra(5'd3, 5'd4, 5'd0, 5'd0);
    #2;
    chk("busy3_before_edge", 32'(rbusy[0]), 32'h0);
    tick();
    iss_valid = 1'b0;
    #2;
    chk("busy3_set", 32'(rbusy[0]), 32'h1);
    we = 1'b1; wa = 5'd3; wd = 32'h33;
    iss_valid = 1'b1; iss_rd = 5'd3;
    #2;
    chk("busy3_same_cycle", 32'(rbusy[0]), BYP ? 32'h0 : 32'h1);
    tick();
    we = 1'b0; iss_valid = 1'b0;
    #2;
    chk("busy3_set_wins", 32'(rbusy[0]), 32'h1);
    we = 1'b1; wa = 5'd3; wd = 32'h44;
    iss_valid = 1'b1; iss_rd = 5'd4;
    tick();
    we = 1'b0; iss_valid = 1'b0;
    #2;
    chk("busy3_cleared", 32'(rbusy[0]), 32'h0);
    chk("busy4_set", 32'(rbusy[1]), 32'h1);
    chk("reg3_data", rdata[31:0], 32'h44);
    wr(5'd4, 32'h0);
    #2;
    chk("busy4_cleared", 32'(rbusy[1]), 32'h0);
    iss_valid = 1'b1; iss_rd = 5'd0;
    set_ra(5'd0, 5'd0, 5'd0, 5'd0);
    tick();
    iss_valid = 1'b0;
    #2;
    chk("reg0_never_busy", 32'(rbusy[0]), 32'h0);

    // a0 and four ports on the same register.
    wr(5'd10, 32'h55);
    set_ra(5'd10, 5'd10, 5'd10, 5'd10);
    #2;
    chk("a0_0x55", a0, 32'h55);
    for (int p = 0; p < NRD; p++) chk("dup_port_0x55", rdata[p*XLEN +: XLEN], 32'h55);

    // Reset in the middle of RUN with a pending write outstanding.
    iss_valid = 1'b1; iss_rd = 5'd6;
    tick();
    iss_valid = 1'b0;
    set_ra(5'd6, 5'd10, 5'd7, 5'd5);
    #2;
    chk("busy6_before_reset", 32'(rbusy[0]), 32'h1);
    rst_n = 1'b0;
    #2;
    chk("midrun_a0", a0, 32'h0);
    chk("midrun_init_done", 32'(init_done), 32'h0);
    chk("midrun_rbusy", 32'(rbusy), 32'h0);
    tick();
    run_clear();
    #2;
    chk("reclear_a0", a0, 32'h0);
    chk("reclear_reg7", rdata[2*XLEN +: XLEN], 32'h0);
    chk("reclear_busy6", 32'(rbusy[0]), 32'h0);

    // Reset in the middle of INIT restarts the full clear.
    wr(5'd10, 32'h77);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    run_clear();
    #2;
    chk("midinit_a0", a0, 32'h0);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
